nios_req_ack_bridge: RTL and testbench

Hardware responder for the Nios software request/acknowledge handshake. It takes a software-driven request level and write data from the CPU's output PIOs, runs one valid/ready transfer to a downstream peripheral, and waits for that peripheral's completion pulse. It then drives the `ack` level, which feeds the CPU's 1-bit ACK input PIO, together with the captured response data. Protocol is four-phase: REQ↑ → ACK↑ → REQ↓ → ACK↓.

---
 rtl/nios_req_ack_bridge_if.sv | 27 ++
 rtl/nios_req_ack_bridge.sv | 134 +++++++++++++
 tb/tb_nios_req_ack_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios_req_ack_bridge_if.sv
// CPU-side request/ack PIO signals and downstream valid/ready/done peripheral signals.
// The master modport is the bridge's view; slave is the CPU/peripheral side.
interface nios_req_ack_bridge_if #(
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ack;
  logic              err;
  logic              busy;
  logic [DATA_W-1:0] cpu_rdata;
  logic              periph_valid;
  logic [DATA_W-1:0] periph_wdata;
  logic              periph_ready;
  logic              periph_done;
  logic [DATA_W-1:0] periph_rdata;

  modport master (
    input  cpu_req, cpu_wdata, periph_ready, periph_done, periph_rdata,
    output ack, err, busy, cpu_rdata, periph_valid, periph_wdata
  );

  modport slave (
    output cpu_req, cpu_wdata, periph_ready, periph_done, periph_rdata,
    input  ack, err, busy, cpu_rdata, periph_valid, periph_wdata
  );
endinterface

// File: rtl/nios_req_ack_bridge.sv
// Four-phase REQ/ACK responder: one valid/ready transfer per software request,
// then wait for the peripheral completion pulse (or time out) before raising ack.
module nios_req_ack_bridge #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_req_ack_bridge_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK_HI    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_meta_q;
  logic                req_s_q;
  logic                timeout;

  // cpu_req comes from a software-written PIO and may change at any time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= bus.cpu_req;
      req_s_q    <= req_meta_q;
    end
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    valid_d = valid_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_s_q) begin
          wdata_d = bus.cpu_wdata;
          valid_d = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A handshake on the timeout edge still counts as progress.
        if (valid_q && bus.periph_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (timeout) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.periph_done) begin
          rdata_d = bus.periph_rdata;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end else if (timeout) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.periph_valid = valid_q;
  assign bus.periph_wdata = wdata_q;

endmodule

// File: tb/tb_nios_req_ack_bridge.sv
// Directed bench for nios_req_ack_bridge: request data and responses are queued
// as stimulus is driven and checked when the bridge presents them.
module tb_nios_req_ack_bridge;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nios_req_ack_bridge_if #(.DATA_W(DW)) bus ();

  nios_req_ack_bridge #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  resp_t         resp_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [DW-1:0] last_rdata;
  int            checks = 0;
  int            errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [DW-1:0] d);
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    wdata_q.push_back(d);
  endtask

  task automatic wait_valid(input string tag, output int n);
    logic [DW-1:0] w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.periph_valid && n < 20);
    chk({tag, "_valid_rise"}, bus.periph_valid, 1);
    chk({tag, "_wq_depth"}, wdata_q.size(), 1);
    if (wdata_q.size() > 0) begin
      w = wdata_q.pop_front();
      chk({tag, "_periph_wdata"}, bus.periph_wdata, w);
    end
  endtask

  task automatic drive_done(input logic [DW-1:0] d);
    bus.periph_done  = 1'b1;
    bus.periph_rdata = d;
    resp_q.push_back({1'b0, d});
    last_rdata = d;
    tick();
    bus.periph_done  = 1'b0;
    bus.periph_rdata = '0;
  endtask

  task automatic chk_resp(input string tag);
    resp_t r;
    chk({tag, "_ack"}, bus.ack, 1);
    chk({tag, "_rq_depth"}, resp_q.size(), 1);
    if (resp_q.size() > 0) begin
      r = resp_q.pop_front();
      chk({tag, "_cpu_rdata"}, bus.cpu_rdata, r.rdata);
      chk({tag, "_err"}, bus.err, r.err);
    end
  endtask

  task automatic release_req(input string tag);
    bus.cpu_req = 1'b0;
    tick();
    chk({tag, "_ack_f0"}, bus.ack, 1);
    tick();
    chk({tag, "_ack_f1"}, bus.ack, 1);
    tick();
    chk({tag, "_ack_f2"}, bus.ack, 0);
    chk({tag, "_busy_f2"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    int hi;
    int stable;
    reset_n          = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_wdata    = '0;
    bus.periph_ready = 1'b0;
    bus.periph_done  = 1'b0;
    bus.periph_rdata = '0;
    last_rdata       = '0;

    // Reset values
    tick();
    tick();
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.periph_valid, 0);
    chk("rst_wdata", bus.periph_wdata, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    reset_n = 1'b1;
    tick();

    // Basic zero-wait transfer
    bus.periph_ready = 1'b1;
    start(8'hA5);
    wait_valid("basic", n);
    chk("basic_valid_latency", n, 3);
    chk("basic_busy", bus.busy, 1);
    tick();
    chk("basic_one_valid_cycle", bus.periph_valid, 0);
    chk("basic_ack_early", bus.ack, 0);
    drive_done(8'h3C);
    chk_resp("basic");
    release_req("basic");

    // Backpressure: ready low for 10 cycles
    bus.periph_ready = 1'b0;
    start(8'h5A);
    wait_valid("bp", n);
    hi = 1;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.periph_valid) hi++;
      if (bus.periph_wdata !== 8'h5A) stable = 0;
    end
    bus.periph_ready = 1'b1;
    tick();
    bus.periph_ready = 1'b0;
    chk("bp_valid_cycles", hi, 11);
    chk("bp_wdata_stable", stable, 1);
    chk("bp_single_accept", bus.periph_valid, 0);
    tick();
    tick();
    chk("bp_ack_before_done", bus.ack, 0);
    drive_done(8'hC3);
    chk_resp("bp");
    release_req("bp");

    // Timeout: peripheral never ready
    start(8'h11);
    wait_valid("to", n);
    resp_q.push_back({1'b1, last_rdata});
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ack && n < 40);
    chk("to_edges", n, TO);
    chk("to_valid_dropped", bus.periph_valid, 0);
    chk_resp("to");
    release_req("to");

    // Next transaction clears err; done coincides with timeout edge
    start(8'h22);
    wait_valid("coin", n);
    chk("coin_err_cleared", bus.err, 0);
    bus.periph_ready = 1'b1;
    tick();
    bus.periph_ready = 1'b0;
    chk("coin_accept", bus.periph_valid, 0);
    repeat (14) tick();
    chk("coin_ack_before_done", bus.ack, 0);
    drive_done(8'h77);
    chk_resp("coin");
    release_req("coin");

    // Request dropped during WAIT_DONE
    bus.periph_ready = 1'b1;
    start(8'h66);
    wait_valid("abort", n);
    tick();
    bus.periph_ready = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (3) tick();
    chk("abort_busy_wait", bus.busy, 1);
    drive_done(8'h99);
    chk_resp("abort");
    tick();
    chk("abort_ack_one_cycle", bus.ack, 0);
    chk("abort_idle", bus.busy, 0);

    // Later request after abort proceeds normally
    bus.periph_ready = 1'b1;
    start(8'h12);
    wait_valid("after", n);
    chk("after_latency", n, 3);
    tick();
    bus.periph_ready = 1'b0;
    drive_done(8'h34);
    chk_resp("after");
    release_req("after");

    // Reset during ISSUE with valid high
    start(8'h5C);
    wait_valid("rmid", n);
    reset_n = 1'b0;
    #1;
    chk("rmid_valid", bus.periph_valid, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_wdata", bus.periph_wdata, 0);
    chk("rmid_rdata", bus.cpu_rdata, 0);
    chk("rmid_ack", bus.ack, 0);
    last_rdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
    wdata_q.push_back(8'h5C);
    wait_valid("rpost", n);
    chk("rpost_latency", n, 3);
    bus.periph_ready = 1'b1;
    tick();
    bus.periph_ready = 1'b0;
    drive_done(8'hE1);
    chk_resp("rpost");
    release_req("rpost");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
